// File: rtl/ff_pipe_asyn_clr_en_if.sv
// Handshake and data bundle for the elastic register pipeline.
// slave is the pipeline's view; master is the surrounding logic's view.
interface ff_pipe_asyn_clr_en_if #(
    parameter int S = 12,
    parameter int N = 4
);
    localparam int CW = $clog2(N + 1);

    logic          IN_VALID;
    logic          IN_READY;
    logic [S-1:0]  D;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [S-1:0]  Q;
    logic [CW-1:0] COUNT;

    modport slave (
        input  IN_VALID,
        input  D,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output Q,
        output COUNT
    );

    modport master (
        output IN_VALID,
        output D,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  Q,
        input  COUNT
    );
endinterface

// File: rtl/ff_pipe_asyn_clr_en.sv
// Elastic N-stage S-bit register pipeline with bubble collapsing; FF_PIPE_FLUSH_EN adds a synchronous FLUSH input.
// Latency N edges at full throughput; OUT_READY low stalls only occupied stages and reaches IN_READY combinationally.
module ff_pipe_asyn_clr_en #(
    parameter int           S       = 12,
    parameter int           N       = 4,
    parameter logic [S-1:0] CLR_VAL = '0
) (
    input  logic CLK,
    input  logic CLR,
    input  logic E,
`ifdef FF_PIPE_FLUSH_EN
    input  logic FLUSH,
`endif
    ff_pipe_asyn_clr_en_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    logic                flush;
    logic [N-1:0]        v_q;
    logic [N-1:0]        v_d;
    logic [N-1:0][S-1:0] d_q;
    logic [N-1:0][S-1:0] d_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic [N-1:0]        rdy;
    logic                acc;
    logic                in_ready;
    logic                in_xfer;
    logic                out_xfer;

`ifdef FF_PIPE_FLUSH_EN
    assign flush = FLUSH;
`else
    assign flush = 1'b0;
`endif

    // A stage may load when it or any stage downstream of it has room.
    always_comb begin
        acc = bus.OUT_READY;
        rdy = '0;
        for (int k = N - 1; k >= 0; k--) begin
            acc    = acc | ~v_q[k];
            rdy[k] = acc;
        end
    end

    assign in_ready = E & rdy[0] & ~flush;
    assign in_xfer  = bus.IN_VALID & in_ready;
    assign out_xfer = v_q[N-1] & bus.OUT_READY & E;

    always_comb begin
        v_d     = v_q;
        d_d     = d_q;
        count_d = count_q;
        if (flush) begin
            v_d     = '0;
            count_d = '0;
        end else if (E) begin
            if (rdy[0]) begin
                v_d[0] = bus.IN_VALID;
                if (bus.IN_VALID) begin
                    d_d[0] = bus.D;
                end
            end
            // Data registers only capture real words so Q keeps its last value across bubbles.
            for (int k = 1; k < N; k++) begin
                if (rdy[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
            if (in_xfer && !out_xfer) begin
                count_d = count_q + 1'b1;
            end else if (out_xfer && !in_xfer) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            v_q     <= '0;
            d_q     <= {N{CLR_VAL}};
            count_q <= '0;
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = v_q[N-1];
    assign bus.Q         = d_q[N-1];
    assign bus.COUNT     = count_q;
endmodule
